// File: rtl/mem_stage_if.sv
// Pipeline-side and memory-side signals of the MEM stage.
// The master modport is the mem_stage itself, which drives the memory request and the writeback.
// The slave modport is its environment: the EX/MEM register, the data memory and MEM/WB.
interface mem_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_store_data;
   logic [2:0]  in_funct3;
   logic        in_mem_read;
   logic        in_mem_write;
   logic [4:0]  in_rd;
   logic        in_load_regfile;
   logic [31:0] in_result;

   logic        data_mem_read;
   logic        data_mem_write;
   logic [31:0] data_mem_address;
   logic [31:0] data_mem_wdata;
   logic [3:0]  data_mem_mbe;
   logic        data_mem_resp;
   logic [31:0] data_mem_rdata;

   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        wb_load_regfile;
   logic [31:0] wb_data;
   logic        wb_misaligned;

   modport master (
      input  in_valid, in_addr, in_store_data, in_funct3, in_mem_read, in_mem_write,
      input  in_rd, in_load_regfile, in_result, data_mem_resp, data_mem_rdata,
      output in_ready, data_mem_read, data_mem_write, data_mem_address, data_mem_wdata,
      output data_mem_mbe, wb_valid, wb_rd, wb_load_regfile, wb_data, wb_misaligned
   );

   modport slave (
      output in_valid, in_addr, in_store_data, in_funct3, in_mem_read, in_mem_write,
      output in_rd, in_load_regfile, in_result, data_mem_resp, data_mem_rdata,
      input  in_ready, data_mem_read, data_mem_write, data_mem_address, data_mem_wdata,
      input  data_mem_mbe, wb_valid, wb_rd, wb_load_regfile, wb_data, wb_misaligned
   );
endinterface

// File: rtl/mem_stage.sv
// RISC-V MEM stage: aligns and issues one data-memory access at a time, extracts and
// extends load data, and produces a one-cycle writeback pulse. Misaligned or illegal
// accesses never reach memory; they complete as a faulted writeback instead.
module mem_stage (
   input logic         clk,
   input logic         rst,
   mem_stage_if.master bus
);

   typedef enum logic [0:0] {StIdle, StAccess} state_e;

   state_e      state_q;
   logic        mem_read_q;
   logic        mem_write_q;
   logic [31:0] address_q;
   logic [31:0] wdata_q;
   logic [3:0]  mbe_q;
   logic [2:0]  funct3_q;
   logic [1:0]  lane_q;
   logic [4:0]  rd_q;
   logic        load_regfile_q;
   logic        wb_valid_q;
   logic [4:0]  wb_rd_q;
   logic        wb_load_regfile_q;
   logic [31:0] wb_data_q;
   logic        wb_misaligned_q;

   logic        is_mem;
   logic        legal;
   logic        aligned;
   logic        fault;
   logic [3:0]  req_mbe;
   logic [31:0] req_wdata;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;

   // Decode the incoming access: legality, alignment, byte lanes and replicated store data.
   always_comb begin
      is_mem    = bus.in_mem_read | bus.in_mem_write;
      legal     = 1'b0;
      aligned   = 1'b1;
      req_mbe   = 4'b1111;
      req_wdata = bus.in_store_data;
      case (bus.in_funct3)
         3'b000: begin
            legal     = 1'b1;
            req_mbe   = 4'b0001 << bus.in_addr[1:0];
            req_wdata = {4{bus.in_store_data[7:0]}};
         end
         3'b001: begin
            legal     = 1'b1;
            aligned   = ~bus.in_addr[0];
            req_mbe   = 4'b0011 << bus.in_addr[1:0];
            req_wdata = {2{bus.in_store_data[15:0]}};
         end
         3'b010: begin
            legal   = 1'b1;
            aligned = (bus.in_addr[1:0] == 2'b00);
         end
         // lbu/lhu exist only as loads
         3'b100: legal = ~bus.in_mem_write;
         3'b101: begin
            legal   = ~bus.in_mem_write;
            aligned = ~bus.in_addr[0];
         end
         default: legal = 1'b0;
      endcase
      // Loads always fetch the whole word; lane selection happens on the way back.
      if (!bus.in_mem_write) begin
         req_mbe = 4'b1111;
      end
      fault = ~legal | ~aligned | (bus.in_mem_read & bus.in_mem_write);
   end

   // Pick the addressed byte/half of the returned word and extend it.
   always_comb begin
      case (lane_q)
         2'd0:    ld_byte = bus.data_mem_rdata[7:0];
         2'd1:    ld_byte = bus.data_mem_rdata[15:8];
         2'd2:    ld_byte = bus.data_mem_rdata[23:16];
         default: ld_byte = bus.data_mem_rdata[31:24];
      endcase
      ld_half = lane_q[1] ? bus.data_mem_rdata[31:16] : bus.data_mem_rdata[15:0];
      case (funct3_q)
         3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  load_data = {24'b0, ld_byte};
         3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  load_data = {16'b0, ld_half};
         default: load_data = bus.data_mem_rdata;
      endcase
   end

   // FSM with registered request and writeback outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q           <= StIdle;
         mem_read_q        <= 1'b0;
         mem_write_q       <= 1'b0;
         address_q         <= '0;
         wdata_q           <= '0;
         mbe_q             <= '0;
         funct3_q          <= '0;
         lane_q            <= '0;
         rd_q              <= '0;
         load_regfile_q    <= 1'b0;
         wb_valid_q        <= 1'b0;
         wb_rd_q           <= '0;
         wb_load_regfile_q <= 1'b0;
         wb_data_q         <= '0;
         wb_misaligned_q   <= 1'b0;
      end else begin
         wb_valid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.in_valid) begin
                  if (!is_mem) begin
                     wb_valid_q        <= 1'b1;
                     wb_rd_q           <= bus.in_rd;
                     wb_load_regfile_q <= bus.in_load_regfile;
                     wb_data_q         <= bus.in_result;
                     wb_misaligned_q   <= 1'b0;
                  end else if (fault) begin
                     wb_valid_q        <= 1'b1;
                     wb_rd_q           <= bus.in_rd;
                     wb_load_regfile_q <= 1'b0;
                     wb_data_q         <= '0;
                     wb_misaligned_q   <= 1'b1;
                  end else begin
                     state_q        <= StAccess;
                     mem_read_q     <= bus.in_mem_read;
                     mem_write_q    <= bus.in_mem_write;
                     address_q      <= {bus.in_addr[31:2], 2'b00};
                     wdata_q        <= req_wdata;
                     mbe_q          <= req_mbe;
                     funct3_q       <= bus.in_funct3;
                     lane_q         <= bus.in_addr[1:0];
                     rd_q           <= bus.in_rd;
                     load_regfile_q <= bus.in_mem_read & bus.in_load_regfile;
                  end
               end
            end
            StAccess: begin
               if (bus.data_mem_resp) begin
                  state_q           <= StIdle;
                  mem_read_q        <= 1'b0;
                  mem_write_q       <= 1'b0;
                  wb_valid_q        <= 1'b1;
                  wb_rd_q           <= rd_q;
                  wb_load_regfile_q <= load_regfile_q;
                  wb_data_q         <= mem_read_q ? load_data : 32'b0;
                  wb_misaligned_q   <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.in_ready         = (state_q == StIdle);
   assign bus.data_mem_read    = mem_read_q;
   assign bus.data_mem_write   = mem_write_q;
   assign bus.data_mem_address = address_q;
   assign bus.data_mem_wdata   = wdata_q;
   assign bus.data_mem_mbe     = mbe_q;
   assign bus.wb_valid         = wb_valid_q;
   assign bus.wb_rd            = wb_rd_q;
   assign bus.wb_load_regfile  = wb_load_regfile_q;
   assign bus.wb_data          = wb_data_q;
   assign bus.wb_misaligned    = wb_misaligned_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-low (asserted when 0)
- in_valid  in  1  EX/MEM stage presents an instruction
- in_ready  out  1  block accepts the instruction this cycle
- in_addr  in  32  effective address (ALU result)
- in_store_data  in  32  rs2 value for stores
- in_funct3  in  3  load/store width code
- in_mem_read  in  1  instruction is a load
- in_mem_write  in  1  instruction is a store
- in_rd  in  5  destination register
- in_load_regfile  in  1  instruction writes rd
- in_result  in  32  non-load writeback value
- data_mem_read  out  1  memory read request
- data_mem_write  out  1  memory write request
- data_mem_address  out  32  word-aligned address ({in_addr[31:2],2'b00})
- data_mem_wdata  out  32  lane-replicated store data
- data_mem_mbe  out  4  byte enables
- data_mem_resp  in  1  memory completes the request this cycle
- data_mem_rdata  in  32  read data, valid with data_mem_resp
- wb_valid  out  1  one-cycle pulse: MEM/WB result valid
- wb_rd  out  5  destination register
- wb_load_regfile  out  1  write enable for rd
- wb_data  out  32  writeback value
- wb_misaligned  out  1  access faulted; no memory access performed

Function
REQ-002 The FSM SHALL have states IDLE and ACCESS; in_ready SHALL be 1 only in IDLE.
REQ-003 Acceptance SHALL occur when in_valid=1 and in_ready=1.
REQ-004 An accepted non-memory instruction (in_mem_read=0, in_mem_write=0) SHALL produce wb_valid=1 on the next cycle with wb_data=in_result, wb_rd=in_rd, wb_load_regfile=in_load_regfile; the state SHALL remain IDLE.
REQ-005 An accepted memory instruction SHALL be faulted when lw/sw has addr[1:0]!=0, lh/lhu/sh has addr[0]=1, funct3 is not a legal load/store code, or in_mem_read and in_mem_write are both 1.
REQ-006 A faulted instruction SHALL issue no request and SHALL produce, one cycle later, wb_valid=1, wb_misaligned=1, wb_load_regfile=0 and wb_data=0.
REQ-007 A non-faulted memory instruction SHALL move to ACCESS and register address, mbe, wdata, funct3 and addr[1:0].
REQ-008 In ACCESS, data_mem_read or data_mem_write SHALL be 1 and all request outputs SHALL be held stable until data_mem_resp=1.
REQ-009 Request outputs SHALL be registered: asserted starting the cycle after acceptance and deasserted the cycle after data_mem_resp.
REQ-010 On data_mem_resp in ACCESS, the FSM SHALL return to IDLE; wb_valid SHALL pulse on the following cycle.
REQ-011 Minimum memory-op latency SHALL be acceptance + 2 cycles (resp in first ACCESS cycle); any further resp delay SHALL add one cycle per cycle of delay.
REQ-012 Store lanes: sb mbe=4'b0001<<addr[1:0], wdata={4{data[7:0]}}; sh mbe=4'b0011<<addr[1:0], wdata={2{data[15:0]}}; sw mbe=4'b1111, wdata=data.
REQ-013 For loads, mbe SHALL be 4'b1111.
REQ-014 Loads: lb/lbu SHALL select rdata byte addr[1:0]; lh/lhu SHALL select half addr[1]; lb/lh SHALL sign-extend; lbu/lhu SHALL zero-extend; lw SHALL pass through unchanged.
REQ-015 Stores SHALL complete with wb_load_regfile=0.
REQ-016 data_mem_resp while in IDLE SHALL be ignored.
REQ-017 wb_misaligned SHALL be 0 for all non-faulted results; every wb_* output SHALL update only on a wb_valid cycle.

Reset
REQ-018 While rst=0 at a rising edge, the block SHALL enter IDLE and clear data_mem_read, data_mem_write, wb_valid, wb_load_regfile and wb_misaligned to 0, and clear data_mem_address, data_mem_wdata, data_mem_mbe, wb_rd and wb_data to 0.
REQ-019 Reset asserted during ACCESS SHALL abandon the request: no wb_valid for it, and requests deassert the cycle after the reset edge.

Verification
REQ-020 lb, addr=0x1003, rdata=0x80FF_FF7F, resp after 3 ACCESS cycles -> address 0x1000, held 3 cycles; wb_data=0xFFFF_FF80, wb_valid one cycle after resp.
REQ-021 sh, addr=0x2002, store_data=0x1234_ABCD -> mbe=4'b1100, wdata=0xABCD_ABCD, data_mem_write=1 until resp, wb_load_regfile=0.
REQ-022 lw, addr=0x3001 -> no data_mem_read; next cycle wb_valid=1, wb_misaligned=1, wb_load_regfile=0.
REQ-023 Back-to-back non-memory ops with in_valid held high -> wb_valid on consecutive cycles; in_ready stays 1.
REQ-024 lhu, addr=0x4002, rdata=0xBEEF_0000 -> wb_data=0x0000_BEEF; stray resp in IDLE beforehand -> no effect.
REQ-025 Reset pulsed during ACCESS of a lw -> data_mem_read=0 the next cycle, no wb_valid, in_ready=1.
